dfi_phy_model: RTL and testbench

//  Synthesizable-style 4-phase DFI PHY/DRAM model sitting directly downstream of mc_core's dfi_p0..p3 bus.

---
 rtl/dfi_phy_model_pkg.sv | 36 +++
 rtl/dfi_phy_model_if.sv | 49 ++++
 rtl/dfi_cmd_fifo.sv | 52 +++++
 rtl/dfi_phy_model.sv | 194 +++++++++++++++++++
 tb/tb_dfi_phy_model.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dfi_phy_model_pkg.sv
// Shared types and constants for the 4-phase DFI PHY/DRAM model.
package dfi_phy_model_pkg;
  localparam int NUM_PH    = 4;
  localparam int ADDR_W    = 17;
  localparam int BANK_W    = 3;
  localparam int NUM_BANKS = 8;
  localparam int PH_W      = 64;
  localparam int PHM_W     = 8;
  localparam int BURST_W   = 256;
  localparam int MASK_W    = 32;
  localparam int COL_LSB   = 3;
  localparam int COL_W     = 7;

  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR} dfi_cmd_e;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] row;
    logic [COL_W-1:0]  col;
  } cmd_ent_t;

  function automatic dfi_cmd_e dfi_decode(logic cs_n, logic ras_n, logic cas_n, logic we_n);
    dfi_cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACT;
        3'b010:  c = CMD_PRE;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction
endpackage

// File: rtl/dfi_phy_model_if.sv
// DFI p0..p3 command/data bus between mc_core (master) and the PHY model (slave).
interface dfi_phy_model_if;
  import dfi_phy_model_pkg::*;
  logic [ADDR_W-1:0] dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address;
  logic [BANK_W-1:0] dfi_p0_bank, dfi_p1_bank, dfi_p2_bank, dfi_p3_bank;
  logic dfi_p0_cs_n, dfi_p1_cs_n, dfi_p2_cs_n, dfi_p3_cs_n;
  logic dfi_p0_ras_n, dfi_p1_ras_n, dfi_p2_ras_n, dfi_p3_ras_n;
  logic dfi_p0_cas_n, dfi_p1_cas_n, dfi_p2_cas_n, dfi_p3_cas_n;
  logic dfi_p0_we_n, dfi_p1_we_n, dfi_p2_we_n, dfi_p3_we_n;
  logic [PH_W-1:0] dfi_p0_wrdata, dfi_p1_wrdata, dfi_p2_wrdata, dfi_p3_wrdata;
  logic dfi_p0_wrdata_en, dfi_p1_wrdata_en, dfi_p2_wrdata_en, dfi_p3_wrdata_en;
  logic [PHM_W-1:0] dfi_p0_wrdata_mask, dfi_p1_wrdata_mask, dfi_p2_wrdata_mask, dfi_p3_wrdata_mask;
  logic dfi_p0_rddata_en, dfi_p1_rddata_en, dfi_p2_rddata_en, dfi_p3_rddata_en;
  logic [PH_W-1:0] dfi_p0_rddata, dfi_p1_rddata, dfi_p2_rddata, dfi_p3_rddata;
  logic dfi_p0_rddata_valid, dfi_p1_rddata_valid, dfi_p2_rddata_valid, dfi_p3_rddata_valid;
  logic phy_err;

  modport master (
    output dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address,
           dfi_p0_bank, dfi_p1_bank, dfi_p2_bank, dfi_p3_bank,
           dfi_p0_cs_n, dfi_p1_cs_n, dfi_p2_cs_n, dfi_p3_cs_n,
           dfi_p0_ras_n, dfi_p1_ras_n, dfi_p2_ras_n, dfi_p3_ras_n,
           dfi_p0_cas_n, dfi_p1_cas_n, dfi_p2_cas_n, dfi_p3_cas_n,
           dfi_p0_we_n, dfi_p1_we_n, dfi_p2_we_n, dfi_p3_we_n,
           dfi_p0_wrdata, dfi_p1_wrdata, dfi_p2_wrdata, dfi_p3_wrdata,
           dfi_p0_wrdata_en, dfi_p1_wrdata_en, dfi_p2_wrdata_en, dfi_p3_wrdata_en,
           dfi_p0_wrdata_mask, dfi_p1_wrdata_mask, dfi_p2_wrdata_mask, dfi_p3_wrdata_mask,
           dfi_p0_rddata_en, dfi_p1_rddata_en, dfi_p2_rddata_en, dfi_p3_rddata_en,
    input  dfi_p0_rddata, dfi_p1_rddata, dfi_p2_rddata, dfi_p3_rddata,
           dfi_p0_rddata_valid, dfi_p1_rddata_valid, dfi_p2_rddata_valid, dfi_p3_rddata_valid,
           phy_err
  );

  modport slave (
    input  dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address,
           dfi_p0_bank, dfi_p1_bank, dfi_p2_bank, dfi_p3_bank,
           dfi_p0_cs_n, dfi_p1_cs_n, dfi_p2_cs_n, dfi_p3_cs_n,
           dfi_p0_ras_n, dfi_p1_ras_n, dfi_p2_ras_n, dfi_p3_ras_n,
           dfi_p0_cas_n, dfi_p1_cas_n, dfi_p2_cas_n, dfi_p3_cas_n,
           dfi_p0_we_n, dfi_p1_we_n, dfi_p2_we_n, dfi_p3_we_n,
           dfi_p0_wrdata, dfi_p1_wrdata, dfi_p2_wrdata, dfi_p3_wrdata,
           dfi_p0_wrdata_en, dfi_p1_wrdata_en, dfi_p2_wrdata_en, dfi_p3_wrdata_en,
           dfi_p0_wrdata_mask, dfi_p1_wrdata_mask, dfi_p2_wrdata_mask, dfi_p3_wrdata_mask,
           dfi_p0_rddata_en, dfi_p1_rddata_en, dfi_p2_rddata_en, dfi_p3_rddata_en,
    output dfi_p0_rddata, dfi_p1_rddata, dfi_p2_rddata, dfi_p3_rddata,
           dfi_p0_rddata_valid, dfi_p1_rddata_valid, dfi_p2_rddata_valid, dfi_p3_rddata_valid,
           phy_err
  );
endinterface

// File: rtl/dfi_cmd_fifo.sv
// Synchronous pending-command FIFO. Push on full and pop on empty are ignored;
// full/empty reflect the state at the start of the cycle, so there is no bypass.
module dfi_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rp_q];

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (push_ok) wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
    if (pop_ok)  rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
    cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/dfi_phy_model.sv
// 4-phase DFI PHY/DRAM model: decodes p0..p3 commands, stores bursts, returns reads after RD_LAT.
// Define DFI_PHY_MODEL_CHECK_EN to also flag RD/WR to a closed bank and ACT to an open bank.
module dfi_phy_model
  import dfi_phy_model_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT    = 4,
  parameter int CMD_DEPTH = 8
) (
  input logic            sys_clk,
  input logic            sys_rst,
  dfi_phy_model_if.slave dfi
);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int ENT_W = $bits(cmd_ent_t);

  logic [NUM_PH-1:0][ADDR_W-1:0] addr;
  logic [NUM_PH-1:0][BANK_W-1:0] bank;
  logic [NUM_PH-1:0]             cs_n, ras_n, cas_n, we_n;
  logic [BURST_W-1:0]            wdata;
  logic [MASK_W-1:0]             wmask;
  dfi_cmd_e                      cmd [NUM_PH];

  assign addr  = {dfi.dfi_p3_address, dfi.dfi_p2_address, dfi.dfi_p1_address, dfi.dfi_p0_address};
  assign bank  = {dfi.dfi_p3_bank, dfi.dfi_p2_bank, dfi.dfi_p1_bank, dfi.dfi_p0_bank};
  assign cs_n  = {dfi.dfi_p3_cs_n, dfi.dfi_p2_cs_n, dfi.dfi_p1_cs_n, dfi.dfi_p0_cs_n};
  assign ras_n = {dfi.dfi_p3_ras_n, dfi.dfi_p2_ras_n, dfi.dfi_p1_ras_n, dfi.dfi_p0_ras_n};
  assign cas_n = {dfi.dfi_p3_cas_n, dfi.dfi_p2_cas_n, dfi.dfi_p1_cas_n, dfi.dfi_p0_cas_n};
  assign we_n  = {dfi.dfi_p3_we_n, dfi.dfi_p2_we_n, dfi.dfi_p1_we_n, dfi.dfi_p0_we_n};
  assign wdata = {dfi.dfi_p3_wrdata, dfi.dfi_p2_wrdata, dfi.dfi_p1_wrdata, dfi.dfi_p0_wrdata};
  assign wmask = {dfi.dfi_p3_wrdata_mask, dfi.dfi_p2_wrdata_mask,
                  dfi.dfi_p1_wrdata_mask, dfi.dfi_p0_wrdata_mask};

  // mc_core drives the enables on every phase; only p0 is meaningful.
  logic unused_en;
  assign unused_en = &{dfi.dfi_p1_wrdata_en, dfi.dfi_p2_wrdata_en, dfi.dfi_p3_wrdata_en,
                       dfi.dfi_p1_rddata_en, dfi.dfi_p2_rddata_en, dfi.dfi_p3_rddata_en};

  for (genvar p = 0; p < NUM_PH; p++) begin : g_dec
    assign cmd[p] = dfi_decode(cs_n[p], ras_n[p], cas_n[p], we_n[p]);
  end

  function automatic logic [AW-1:0] ent_idx(cmd_ent_t e);
    logic [ENT_W-1:0] flat;
    flat = {e.row, e.bank, e.col};
    return flat[AW-1:0];
  endfunction

  logic [NUM_BANKS-1:0][ADDR_W-1:0] open_row_q, open_row_d;
`ifdef DFI_PHY_MODEL_CHECK_EN
  logic [NUM_BANKS-1:0]             bank_open_q, bank_open_d;
`endif
  logic     cas_seen, cas_rd, multi_cas, chk_err;
  cmd_ent_t cas_ent;

  // Phases resolve in order so an ACT on an earlier phase feeds a CAS later in the same cycle.
  always_comb begin
    open_row_d = open_row_q;
`ifdef DFI_PHY_MODEL_CHECK_EN
    bank_open_d = bank_open_q;
`endif
    cas_seen  = 1'b0;
    cas_rd    = 1'b0;
    multi_cas = 1'b0;
    chk_err   = 1'b0;
    cas_ent   = '0;
    for (int p = 0; p < NUM_PH; p++) begin
      case (cmd[p])
        CMD_ACT: begin
`ifdef DFI_PHY_MODEL_CHECK_EN
          if (bank_open_d[bank[p]]) chk_err = 1'b1;
          bank_open_d[bank[p]] = 1'b1;
`endif
          open_row_d[bank[p]] = addr[p];
        end
        CMD_PRE: begin
`ifdef DFI_PHY_MODEL_CHECK_EN
          if (addr[p][10]) bank_open_d = '0;
          else             bank_open_d[bank[p]] = 1'b0;
`endif
        end
        CMD_RD, CMD_WR: begin
          if (cas_seen) begin
            multi_cas = 1'b1;
          end else begin
            cas_seen     = 1'b1;
            cas_rd       = (cmd[p] == CMD_RD);
            cas_ent.bank = bank[p];
            cas_ent.row  = open_row_d[bank[p]];
            cas_ent.col  = addr[p][COL_LSB +: COL_W];
`ifdef DFI_PHY_MODEL_CHECK_EN
            if (!bank_open_d[bank[p]]) chk_err = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  logic     rd_push, wr_push, rd_full, wr_full, rd_empty, wr_empty;
  cmd_ent_t rd_dout, wr_dout;

  assign rd_push = cas_seen &&  cas_rd;
  assign wr_push = cas_seen && !cas_rd;

  dfi_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(ENT_W)) u_rd_fifo (
    .clk(sys_clk), .rst(sys_rst), .push(rd_push), .din(cas_ent),
    .pop(dfi.dfi_p0_rddata_en), .dout(rd_dout), .full(rd_full), .empty(rd_empty)
  );

  dfi_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(ENT_W)) u_wr_fifo (
    .clk(sys_clk), .rst(sys_rst), .push(wr_push), .din(cas_ent),
    .pop(dfi.dfi_p0_wrdata_en), .dout(wr_dout), .full(wr_full), .empty(wr_empty)
  );

  logic [BURST_W-1:0]            mem_q [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]          ent_vld_q, ent_vld_d;
  logic                          wr_do, rd_do;
  logic [AW-1:0]                 wr_idx, rd_idx;
  logic [BURST_W-1:0]            rd_data;
  logic [RD_LAT:1]               vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1][BURST_W-1:0]  dat_pipe_q, dat_pipe_d;
  logic                          phy_err_q, phy_err_d;

  assign wr_do   = dfi.dfi_p0_wrdata_en && !wr_empty && !sys_rst;
  assign rd_do   = dfi.dfi_p0_rddata_en && !rd_empty && !sys_rst;
  assign wr_idx  = ent_idx(wr_dout);
  assign rd_idx  = ent_idx(rd_dout);
  // Array is read before this cycle's write lands, so a colliding read sees old data.
  assign rd_data = ent_vld_q[rd_idx] ? mem_q[rd_idx] : '0;

  always_comb begin
    ent_vld_d = ent_vld_q;
    if (wr_do) ent_vld_d[wr_idx] = 1'b1;
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = rd_do;
    dat_pipe_d[1] = rd_do ? rd_data : '0;
    for (int s = 2; s <= RD_LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      dat_pipe_d[s] = dat_pipe_q[s-1];
    end
    phy_err_d = phy_err_q | multi_cas | chk_err
              | (rd_push && rd_full) | (wr_push && wr_full)
              | (dfi.dfi_p0_rddata_en && rd_empty) | (dfi.dfi_p0_wrdata_en && wr_empty);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      open_row_q <= '0;
`ifdef DFI_PHY_MODEL_CHECK_EN
      bank_open_q <= '0;
`endif
      ent_vld_q  <= '0;
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      phy_err_q  <= 1'b0;
    end else begin
      open_row_q <= open_row_d;
`ifdef DFI_PHY_MODEL_CHECK_EN
      bank_open_q <= bank_open_d;
`endif
      ent_vld_q  <= ent_vld_d;
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      phy_err_q  <= phy_err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_do) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wmask[b]) mem_q[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

`ifdef DFI_PHY_MODEL_CHECK_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && chk_err) $error("dfi_phy_model: DRAM protocol violation");
  end
`endif

  assign dfi.dfi_p0_rddata       = dat_pipe_q[RD_LAT][0*PH_W +: PH_W];
  assign dfi.dfi_p1_rddata       = dat_pipe_q[RD_LAT][1*PH_W +: PH_W];
  assign dfi.dfi_p2_rddata       = dat_pipe_q[RD_LAT][2*PH_W +: PH_W];
  assign dfi.dfi_p3_rddata       = dat_pipe_q[RD_LAT][3*PH_W +: PH_W];
  assign dfi.dfi_p0_rddata_valid = vld_pipe_q[RD_LAT];
  assign dfi.dfi_p1_rddata_valid = vld_pipe_q[RD_LAT];
  assign dfi.dfi_p2_rddata_valid = vld_pipe_q[RD_LAT];
  assign dfi.dfi_p3_rddata_valid = vld_pipe_q[RD_LAT];
  assign dfi.phy_err             = phy_err_q;
endmodule

// File: tb/tb_dfi_phy_model.sv
// Directed bench for dfi_phy_model with a queue/array-level reference model checked every cycle.
module tb_dfi_phy_model;
  import dfi_phy_model_pkg::*;
  localparam int MEM_DEPTH = 256;
  localparam int RD_LAT    = 4;
  localparam int CMD_DEPTH = 8;
  localparam logic [3:0] C_NOP = 4'b1111, C_ACT = 4'b0011, C_PRE = 4'b0010,
                         C_RD  = 4'b0101, C_WR  = 4'b0100;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  dfi_phy_model_if dif();
  dfi_phy_model #(.MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT), .CMD_DEPTH(CMD_DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dfi(dif)
  );

  logic [16:0] a_addr [4];
  logic [2:0]  a_bank [4];
  logic [3:0]  a_cmd  [4];   // {cs_n, ras_n, cas_n, we_n}
  logic [63:0] a_wd   [4];
  logic [7:0]  a_wm   [4];
  logic        a_wen, a_ren;

  assign {dif.dfi_p0_address, dif.dfi_p1_address, dif.dfi_p2_address, dif.dfi_p3_address} =
         {a_addr[0], a_addr[1], a_addr[2], a_addr[3]};
  assign {dif.dfi_p0_bank, dif.dfi_p1_bank, dif.dfi_p2_bank, dif.dfi_p3_bank} =
         {a_bank[0], a_bank[1], a_bank[2], a_bank[3]};
  assign {dif.dfi_p0_cs_n, dif.dfi_p0_ras_n, dif.dfi_p0_cas_n, dif.dfi_p0_we_n} = a_cmd[0];
  assign {dif.dfi_p1_cs_n, dif.dfi_p1_ras_n, dif.dfi_p1_cas_n, dif.dfi_p1_we_n} = a_cmd[1];
  assign {dif.dfi_p2_cs_n, dif.dfi_p2_ras_n, dif.dfi_p2_cas_n, dif.dfi_p2_we_n} = a_cmd[2];
  assign {dif.dfi_p3_cs_n, dif.dfi_p3_ras_n, dif.dfi_p3_cas_n, dif.dfi_p3_we_n} = a_cmd[3];
  assign {dif.dfi_p0_wrdata, dif.dfi_p1_wrdata, dif.dfi_p2_wrdata, dif.dfi_p3_wrdata} =
         {a_wd[0], a_wd[1], a_wd[2], a_wd[3]};
  assign {dif.dfi_p0_wrdata_mask, dif.dfi_p1_wrdata_mask, dif.dfi_p2_wrdata_mask,
          dif.dfi_p3_wrdata_mask} = {a_wm[0], a_wm[1], a_wm[2], a_wm[3]};
  assign {dif.dfi_p0_wrdata_en, dif.dfi_p1_wrdata_en, dif.dfi_p2_wrdata_en, dif.dfi_p3_wrdata_en} = {4{a_wen}};
  assign {dif.dfi_p0_rddata_en, dif.dfi_p1_rddata_en, dif.dfi_p2_rddata_en, dif.dfi_p3_rddata_en} = {4{a_ren}};

  wire [255:0] rd_bus = {dif.dfi_p3_rddata, dif.dfi_p2_rddata, dif.dfi_p1_rddata, dif.dfi_p0_rddata};
  wire [3:0]   rd_vld = {dif.dfi_p3_rddata_valid, dif.dfi_p2_rddata_valid,
                         dif.dfi_p1_rddata_valid, dif.dfi_p0_rddata_valid};

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction

  // Reference model: command queues, sparse memory, and a table of when each read burst is due.
  logic [16:0]  m_row [8];
  int           m_rq[$], m_wq[$];
  logic [255:0] m_mem [int];
  logic [255:0] m_sched [int];
  bit           m_err;
  int           ecnt = 0;

  always @(posedge sys_clk) begin : model
    bit cas, is_rd, rfull, wfull;
    int idx, i;
    logic [255:0] d, wd;
    logic [31:0]  wm;
    ecnt++;
    if (sys_rst) begin
      foreach (m_row[b]) m_row[b] = '0;
      m_rq.delete(); m_wq.delete(); m_mem.delete(); m_sched.delete();
      m_err = 1'b0;
    end else begin
      cas = 1'b0; is_rd = 1'b0; idx = 0;
      for (int p = 0; p < 4; p++) begin
        case (a_cmd[p])
          C_ACT: m_row[a_bank[p]] = a_addr[p];
          C_RD, C_WR: begin
            if (cas) m_err = 1'b1;
            else begin
              cas   = 1'b1;
              is_rd = (a_cmd[p] == C_RD);
              idx   = int'({m_row[a_bank[p]], a_bank[p], a_addr[p][9:3]}) % MEM_DEPTH;
            end
          end
          default: ;
        endcase
      end
      rfull = (m_rq.size() >= CMD_DEPTH);
      wfull = (m_wq.size() >= CMD_DEPTH);
      if (a_ren) begin
        if (m_rq.size() == 0) m_err = 1'b1;
        else begin
          i = m_rq.pop_front();
          m_sched[ecnt + RD_LAT - 1] = m_mem.exists(i) ? m_mem[i] : '0;
        end
      end
      if (a_wen) begin
        if (m_wq.size() == 0) m_err = 1'b1;
        else begin
          i  = m_wq.pop_front();
          d  = m_mem.exists(i) ? m_mem[i] : '0;
          wd = {a_wd[3], a_wd[2], a_wd[1], a_wd[0]};
          wm = {a_wm[3], a_wm[2], a_wm[1], a_wm[0]};
          for (int b = 0; b < 32; b++) if (!wm[b]) d[b*8 +: 8] = wd[b*8 +: 8];
          m_mem[i] = d;
        end
      end
      if (cas) begin
        if (is_rd) begin if (rfull) m_err = 1'b1; else m_rq.push_back(idx); end
        else       begin if (wfull) m_err = 1'b1; else m_wq.push_back(idx); end
      end
    end
  end

  always @(negedge sys_clk) begin : compare
    bit ev;
    if (ecnt >= 1) begin
      ev = m_sched.exists(ecnt);
      chk("cyc_valid", 256'(rd_vld), 256'({4{ev}}));
      if (ev) chk("cyc_rddata", rd_bus, m_sched[ecnt]);
      chk("cyc_phy_err", 256'(dif.phy_err), 256'(m_err));
    end
  end

  task automatic idle_inputs();
    for (int p = 0; p < 4; p++) begin
      a_cmd[p] = C_NOP; a_addr[p] = '0; a_bank[p] = '0; a_wd[p] = '0; a_wm[p] = '0;
    end
    a_wen = 1'b0; a_ren = 1'b0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
    idle_inputs();
  endtask

  task automatic cmd(int p, logic [3:0] c, logic [2:0] b, logic [16:0] a);
    a_cmd[p] = c; a_bank[p] = b; a_addr[p] = a;
  endtask

  task automatic wdat(logic [255:0] d, logic [31:0] m);
    for (int p = 0; p < 4; p++) begin
      a_wd[p] = d[64*p +: 64]; a_wm[p] = m[8*p +: 8];
    end
    a_wen = 1'b1;
  endtask

  task automatic wait_lat();
    repeat (RD_LAT - 1) tick();
  endtask

  logic [255:0] ones, pat;

  initial begin
    ones = '1;
    idle_inputs();
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    chk("reset_valid", 256'(rd_vld), '0);
    chk("reset_rddata", rd_bus, '0);
    chk("reset_err", 256'(dif.phy_err), '0);

    // 1: ACT+WR same cycle, data pop, then read back
    cmd(0, C_ACT, 3'd1, 17'h12); cmd(1, C_WR, 3'd1, 17'h40); tick();
    wdat(256'h1, 32'h0); tick();
    cmd(0, C_RD, 3'd1, 17'h40); tick();
    a_ren = 1'b1; tick();
    wait_lat();
    chk("t1_valid", 256'(rd_vld), 256'hF);
    chk("t1_data", rd_bus, 256'h1);
    chk("t1_err", 256'(dif.phy_err), '0);

    // 2: full write then byte-masked overwrite
    cmd(0, C_WR, 3'd1, 17'h80); tick();
    wdat(ones, 32'h0); cmd(0, C_WR, 3'd1, 17'h80); tick();
    wdat('0, 32'hFFFF_FFFE); tick();
    cmd(0, C_RD, 3'd1, 17'h80); tick();
    a_ren = 1'b1; tick();
    wait_lat();
    chk("t2_masked", rd_bus, {ones[255:8], 8'h00});

    // same-cycle write pop and read pop to one index: read sees old data
    cmd(0, C_WR, 3'd1, 17'h80); tick();
    cmd(0, C_RD, 3'd1, 17'h80); tick();
    wdat({4{64'h5A5A_5A5A_5A5A_5A5A}}, 32'h0); a_ren = 1'b1; tick();
    wait_lat();
    chk("rw_collide_old", rd_bus, {ones[255:8], 8'h00});

    // 3: never-written index reads zero
    cmd(0, C_RD, 3'd2, 17'h18); tick();
    a_ren = 1'b1; tick();
    wait_lat();
    chk("t3_valid", 256'(rd_vld), 256'hF);
    chk("t3_data", rd_bus, '0);

    // 4: underflow is sticky
    a_ren = 1'b1; tick();
    chk("t4_err", 256'(dif.phy_err), 256'h1);
    repeat (RD_LAT + 1) tick();
    chk("t4_no_valid", 256'(rd_vld), '0);
    chk("t4_sticky", 256'(dif.phy_err), 256'h1);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    chk("t4_rst_clear", 256'(dif.phy_err), '0);

    // 5: ninth WR overflows; first eight land
    cmd(0, C_ACT, 3'd3, 17'h7); tick();
    for (int i = 0; i < 9; i++) begin
      cmd(0, C_WR, 3'd3, 17'(i * 8)); tick();
      chk(i < 8 ? "t5_no_ovf" : "t5_ovf", 256'(dif.phy_err), 256'(i >= 8));
    end
    for (int i = 0; i < 8; i++) begin
      pat = {4{64'hA5A5_0000_0000_0000 | 64'(i)}};
      wdat(pat, 32'h0); tick();
    end
    for (int i = 0; i < 8; i++) begin
      cmd(0, C_RD, 3'd3, 17'(i * 8)); tick();
    end
    for (int i = 0; i < 8 + RD_LAT - 1; i++) begin
      a_ren = (i < 8); tick();
      if (i >= RD_LAT - 1) begin
        pat = {4{64'hA5A5_0000_0000_0000 | 64'(i - (RD_LAT - 1))}};
        chk("t5_b2b_data", rd_bus, pat);
      end
    end
    cmd(0, C_RD, 3'd3, 17'(8 * 8)); tick();
    a_ren = 1'b1; tick();
    wait_lat();
    chk("t5_dropped_zero", rd_bus, '0);

    // multi-CAS: lowest phase kept, error flagged
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    cmd(0, C_RD, 3'd3, 17'h0); cmd(2, C_WR, 3'd3, 17'h8); tick();
    chk("multicas_err", 256'(dif.phy_err), 256'h1);
    a_ren = 1'b1; tick();
    wait_lat();
    chk("multicas_rd_kept", 256'(rd_vld), 256'hF);

    // 6: reset mid-flight flushes the pipe
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    cmd(0, C_RD, 3'd3, 17'h0); tick();
    a_ren = 1'b1; tick();
    tick();
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      chk("t6_no_valid", 256'(rd_vld), '0);
      chk("t6_data_zero", rd_bus, '0);
      chk("t6_err", 256'(dif.phy_err), '0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
